ifetch_buffer: RTL
==================

# ifetch_buffer

Instruction prefetch buffer sitting directly upstream of the fetch stage in the Y86-64 pipeline. It reads 8-byte aligned words from instruction memory through a req/ack handshake, holds them in a byte-granular circular queue, and presents a 10-byte window starting at the current fetch PC. Fetch consumes variable-length instructions (1–10 bytes) from that window. A redirect from pc_update flushes the queue and restarts prefetch at the new PC.

## Interface

Parameters:
- BUF_BYTES, 16: queue capacity in bytes; power of two, ≥ 16.
- RESET_PC, 64'h0: fetch PC after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  flush the queue and restart at redirect_pc.
- redirect_pc  in  64  new fetch PC; any byte alignment.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  64  word address, always 8-byte aligned.
- mem_ack  in  1  request accepted, data valid this cycle.
- mem_rdata  in  64  little-endian word; byte 0 in [7:0].
- mem_err  in  1  access fault; qualified by mem_ack.
- win_bytes  out  80  bytes at win_pc onward; byte k in [8k+7:8k]; bytes at index ≥ win_count are 0.
- win_count  out  4  valid window bytes, min(occupancy, 10).
- win_pc  out  64  address of win_bytes byte 0.
- win_err  out  1  memory fault latched and fewer than 10 bytes buffered.
- consume  in  1  fetch takes consume_len bytes.
- consume_len  in  4  1..10.

## Operation

- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding; its data is kept.
  - REQ_STALE: request outstanding; its data is discarded.
- Request issue, IDLE→REQ: when free space ≥ 8, no error latched, and no redirect this cycle. mem_addr = next fetch word address.
- Handshake: mem_req and mem_addr stay stable until a cycle with mem_ack=1. Ack is sampled only while mem_req=1.
- REQ + ack, mem_err=0:
  - Append bytes [skip..7] of mem_rdata to the queue.
  - skip = fetch PC[2:0] for the first word after reset or redirect, 0 otherwise.
  - Next word address += 8. Go to IDLE.
- REQ + ack, mem_err=1: latch err, append nothing, go to IDLE. No further requests until redirect or reset.
- Redirect:
  - Occupancy → 0 and err cleared.
  - win_pc and the head → redirect_pc; next word address → redirect_pc & ~7; skip → redirect_pc[2:0].
  - State: REQ→REQ_STALE, REQ_STALE stays, IDLE stays.
- REQ_STALE + ack: drop the data, ignore mem_err, go to IDLE.
- Consume with 1 ≤ consume_len ≤ win_count: head += consume_len (modulo BUF_BYTES), win_pc += consume_len, occupancy −= consume_len.
- Illegal consume (consume_len = 0 or > win_count): ignored, no state change.
- Simultaneous events:
  - Consume and ack in the same cycle both apply.
  - Free-space check for issuing uses occupancy after both updates.
  - Redirect overrides consume and ack-append in the same cycle.
- Address arithmetic: 64-bit wrap, no overflow flag.

## Timing

- Reset values: mem_req=0, mem_addr=RESET_PC&~7, win_bytes=0, win_count=0, win_pc=RESET_PC, win_err=0, state IDLE.
- First mem_req rises 1 cycle after rst deasserts.
- All outputs are registered. No combinational path from any input to any output.
- Latency:
  - Ack at edge N → bytes visible on win_* after edge N.
  - Redirect at edge N → mem_req=1 after edge N+1 if IDLE; otherwise 1 cycle after the stale ack.
- Zero-wait memory (ack tied high) with no consumption fills the queue to ≥ BUF_BYTES−7 bytes.
- Reset mid-handshake: the request is abandoned. Memory must tolerate mem_req dropping without ack.

## Structure

- Shared package ifetch_pkg:
  - state enum {IDLE, REQ, REQ_STALE}.
  - WIN_BYTES=10, WORD_BYTES=8.
  - Status encodings AOK/HLT/ADR/INS, shared with fetch and the wrapper.
- Sub-module byte_ring (parameter DEPTH):
  - Circular byte storage with head/tail pointers and an occupancy counter.
  - Write port: up to 8 bytes per cycle. Read port: 10-byte window.
  - Flush input.
- ifetch_buffer holds the handshake FSM, address and skip logic, and error latch.

## Test plan

- Reset release, RESET_PC=0, ack=1 every cycle, rdata = byte i holds value i:
  - win_bytes bytes 0..9 = 0x00..0x09, win_count=10, win_pc=0.
  - mem_addr steps 0, 8, 16, …
- consume_len=10 then 1 then 2 → win_pc = 10, 11, 13; byte 0 = 0x0A, 0x0B, 0x0D.
- Redirect to 0x103, ack delayed 3 cycles:
  - mem_addr=0x100.
  - After ack: win_count=5, byte 0 = data byte 3.
- Redirect while REQ outstanding to 0x40:
  - Stale ack data never appears in the window.
  - Next mem_addr=0x40.
- Ack with mem_err=1 at 0x18 after 0x10 is buffered (win_pc=0x10):
  - win_err=1, win_count=8, no further mem_req.
  - Redirect clears win_err.
- consume_len=0xB, and consume_len > win_count → window unchanged.
- rst pulse mid-REQ → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch path and its neighbours.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        REQ_STALE = 2'd2
    } state_t;

    localparam int WIN_BYTES  = 10;
    localparam int WORD_BYTES = 8;

    // Y86-64 status codes, shared with fetch and the wrapper.
    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

    // Number of window bytes visible for a given queue occupancy.
    function automatic logic [3:0] win_clip(input int unsigned occ);
        return (occ >= WIN_BYTES) ? 4'(WIN_BYTES) : 4'(occ);
    endfunction

endpackage

// File: rtl/byte_ring.sv
// Circular byte queue: up to 8 bytes written per cycle, 10-byte window read at the head.
// Latency: a write at edge N is visible on the window right after edge N.
// Backpressure: none internally; the writer only writes when at least 8 bytes are free.
module byte_ring
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [2:0]             wr_skip_i,
    input  logic [63:0]            wr_data_i,
    input  logic                   rd_en_i,
    input  logic [3:0]             rd_len_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [79:0]            win_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    wr_len;
    logic [PW-1:0] wr_idx [WORD_BYTES];
    logic [7:0]    wr_sel;
    logic [PW-1:0] rd_idx [WIN_BYTES];

    // Bytes below the skip offset belong to addresses before the fetch PC and are dropped.
    assign wr_len = 4'(WORD_BYTES) - {1'b0, wr_skip_i};

    // Map each incoming word byte to its slot, packing the kept bytes from the tail.
    always_comb begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            wr_idx[i] = tail_q + PW'(i) - PW'(wr_skip_i);
            wr_sel[i] = wr_en_i && !flush_i && (3'(i) >= wr_skip_i);
        end
    end

    // Byte storage; contents beyond the occupancy are masked on read, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (wr_sel[i]) begin
                mem_q[wr_idx[i]] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Pointer and occupancy update; flush wins over a same-cycle read or write.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rd_en_i) begin
                head_d = head_q + PW'(rd_len_i);
            end
            if (wr_en_i) begin
                tail_d = tail_q + PW'(wr_len);
            end
            count_d = count_q - (rd_en_i ? CW'(rd_len_i) : '0) + (wr_en_i ? CW'(wr_len) : '0);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Window read from registered state only; bytes past the occupancy read as zero.
    always_comb begin
        win_o = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            rd_idx[k] = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                win_o[8*k +: 8] = mem_q[rd_idx[k]];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Y86-64 instruction prefetch buffer: fetches aligned words, presents a 10-byte window at the fetch PC.
// Latency: memory ack at edge N shows on win_* after edge N; redirect issues its request after edge N+1.
// Backpressure: a request is issued only with >= 8 free bytes; req/addr hold until mem_ack.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int          BUF_BYTES = 16,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic [79:0] win_bytes,
    output logic [3:0]  win_count,
    output logic [63:0] win_pc,
    output logic        win_err,
    input  logic        consume,
    input  logic [3:0]  consume_len
);

    localparam int CW = $clog2(BUF_BYTES) + 1;
    localparam logic [CW-1:0] ISSUE_MAX = CW'(BUF_BYTES - WORD_BYTES);

    state_t        state_q, state_d;
    logic [63:0]   word_addr_q, word_addr_d;
    logic [63:0]   req_addr_q, req_addr_d;
    logic [63:0]   pc_q, pc_d;
    logic [2:0]    skip_q, skip_d;
    logic          err_q, err_d;

    logic [CW-1:0] occ;
    logic [CW-1:0] occ_after;
    logic [3:0]    win_count_w;
    logic [3:0]    app_len;
    logic          consume_ok;
    logic          ack_vld;
    logic          append;

    assign win_count_w = win_clip(32'(occ));
    assign consume_ok  = consume && (consume_len != 4'd0) && (consume_len <= win_count_w);
    assign ack_vld     = (state_q != IDLE) && mem_ack;
    assign append      = (state_q == REQ) && mem_ack && !mem_err && !redirect;
    assign app_len     = 4'(WORD_BYTES) - {1'b0, skip_q};
    // Occupancy once this cycle's consume and append have both landed.
    assign occ_after   = occ - (consume_ok ? CW'(consume_len) : '0) + (append ? CW'(app_len) : '0);

    byte_ring #(
        .DEPTH(BUF_BYTES)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (redirect),
        .wr_en_i   (append),
        .wr_skip_i (skip_q),
        .wr_data_i (mem_rdata),
        .rd_en_i   (consume_ok && !redirect),
        .rd_len_i  (consume_len),
        .count_o   (occ),
        .win_o     (win_bytes)
    );

    // Handshake FSM, address/skip tracking and error latch; redirect overrides everything else.
    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        req_addr_d  = req_addr_q;
        pc_d        = pc_q;
        skip_d      = skip_q;
        err_d       = err_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            word_addr_d = {redirect_pc[63:3], 3'b000};
            skip_d      = redirect_pc[2:0];
            err_d       = 1'b0;
            // An ack arriving with the redirect closes the request; its data is dropped.
            case (state_q)
                IDLE:      state_d = IDLE;
                REQ:       state_d = ack_vld ? IDLE : REQ_STALE;
                REQ_STALE: state_d = ack_vld ? IDLE : REQ_STALE;
                default:   state_d = IDLE;
            endcase
        end else begin
            if (consume_ok) begin
                pc_d = pc_q + {60'd0, consume_len};
            end
            case (state_q)
                IDLE: begin
                    if (!err_q && (occ_after <= ISSUE_MAX)) begin
                        state_d    = REQ;
                        req_addr_d = word_addr_q;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_d = IDLE;
                        if (mem_err) begin
                            err_d = 1'b1;
                        end else begin
                            word_addr_d = word_addr_q + 64'd8;
                            skip_d      = 3'd0;
                        end
                    end
                end
                REQ_STALE: begin
                    if (mem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_addr_q <= {RESET_PC[63:3], 3'b000};
            req_addr_q  <= {RESET_PC[63:3], 3'b000};
            pc_q        <= RESET_PC;
            skip_q      <= RESET_PC[2:0];
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            req_addr_q  <= req_addr_d;
            pc_q        <= pc_d;
            skip_q      <= skip_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = req_addr_q;
    assign win_count = win_count_w;
    assign win_pc    = pc_q;
    assign win_err   = err_q && (win_count_w < 4'(WIN_BYTES));

endmodule
